// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Quotient returns on result_lo, remainder on result_hi (LO/HI split).
// One iteration per clock for WIDTH clocks, then a single DONE cycle
// in which ready pulses with the signed-corrected results.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hassign,
  input  logic             start,
  input  logic             annul,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control state (reset)
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;

  // Datapath state (no reset; always loaded on an accepted start)
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] araw_q;
  logic             sgn_quo_q;
  logic             sgn_rem_q;
  logic             dzero_q;

  // Iteration datapath
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  logic accept;
  logic last_iter;

  // Absolute value of a two's-complement operand. The most negative value
  // maps onto itself, which read as unsigned is the correct magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] neg;
    neg = -v;
    return v[WIDTH-1] ? $unsigned(neg) : $unsigned(v);
  endfunction

  // Re-apply a sign to an unsigned magnitude.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                  input logic             neg);
    return neg ? -m : m;
  endfunction

  assign accept    = (state_q == IDLE) && start && !annul;
  assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  // The shifted remainder needs WIDTH+1 bits because a divisor above
  // 2^(WIDTH-1) leaves remainders with the MSB set; bit WIDTH of the
  // WIDTH+1-bit difference is then the borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    if (trial[WIDTH]) begin
      rem_nx = rem_sh[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  // State register plus the registered outputs and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
    end
  end

  // Next-state logic; annul aborts RUN and blocks a start in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (annul)          state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: registered busy/ready follow the next state; results are
  // sign-corrected as the last iteration lands so they are valid in DONE.
  always_comb begin
    busy_d   = (state_d == RUN);
    ready_d  = (state_d == DONE);
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
    end
    if ((state_q == RUN) && (state_d == DONE)) begin
      if (dzero_q) begin
        res_lo_d = '1;
        res_hi_d = araw_q;
      end else begin
        res_lo_d = apply_sign(quo_nx, sgn_quo_q);
        res_hi_d = apply_sign(rem_nx, sgn_rem_q);
      end
    end
  end

  // Operand capture on accept, then one shift/subtract step per RUN cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      quo_q     <= hassign ? magnitude(a) : a;
      dvs_q     <= hassign ? magnitude(b) : b;
      rem_q     <= '0;
      araw_q    <= a;
      sgn_quo_q <= hassign & (a[WIDTH-1] ^ b[WIDTH-1]);
      sgn_rem_q <= hassign & a[WIDTH-1];
      dzero_q   <= (b == '0);
    end else if (state_q == RUN) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  assign busy      = busy_q;
  assign ready     = ready_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and hand-sequenced checks of div_unit with a
// scoreboard queue of expected {quotient, remainder} pairs popped on ready.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         hassign, start, annul;
  logic         busy, ready;
  logic [W-1:0] result_lo, result_hi;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .hassign(hassign),
    .start(start), .annul(annul), .busy(busy), .ready(ready),
    .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      ready_cnt++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ready: got ready=1 with lo=%h hi=%h, want no pending result",
                 result_lo, result_hi);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_lo", result_lo, sb_e.lo);
        check("sb_hi", result_hi, sb_e.hi);
      end
    end
  end

  // Called at #1 after a rising edge (cycle T). Returns at cycle T+34.
  task automatic run_div(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi);
    int bad;
    bad = 0;
    sb_q.push_back('{lo: elo, hi: ehi});
    a = va; b = vb; hassign = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= W; k++) begin
      if (busy !== 1'b1 || ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("busy_window", bad, 0);
    check_bit("ready_at_T+33", ready, 1'b1);
    check_bit("busy_in_done", busy, 1'b0);
    @(posedge clk); #1;
    check_bit("ready_one_pulse", ready, 1'b0);
  endtask

  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    logic signed [W-1:0] sa, sb, sq, sr;
    exp_t r;
    if (vs) begin
      sa = va; sb = vb;
      sq = sa / sb;
      sr = sa % sb;
      r.lo = sq; r.hi = sr;
    end else begin
      r.lo = va / vb;
      r.hi = va % vb;
    end
    return r;
  endfunction

  vec_t         vecs[12];
  exp_t         m;
  logic [W-1:0] ra, rb, prev_lo, prev_hi;
  logic         rs;
  int           bad, rc0;

  initial begin
    vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
    vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
    vecs[4]  = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000};
    vecs[5]  = '{32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5};
    vecs[6]  = '{32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,   32'd5};
    vecs[7]  = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFB};
    vecs[8]  = '{32'hFFFFFFFF,   32'h80000001,   1'b0, 32'd1,          32'h7FFFFFFE};
    vecs[9]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE};
    vecs[10] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0};
    vecs[11] = '{32'd0,          32'd5,          1'b1, 32'd0,          32'd0};

    rst = 1'b1; a = '0; b = '0; hassign = 1'b0; start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_ready", ready, 1'b0);
    check("reset_lo", result_lo, '0);
    check("reset_hi", result_hi, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table vectors, issued back to back (each start lands the cycle after DONE)
    for (int i = 0; i < 12; i++)
      run_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lo, vecs[i].hi);

    // Random operands against a behavioural model
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 1) ? $urandom : $urandom_range(1, 500);
      if (i == 4) rb = -rb;
      if (rb == '0) rb = 32'd1;
      rs = (i % 3 != 0);
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      m = model(ra, rb, rs);
      run_div(ra, rb, rs, m.lo, m.hi);
    end

    // Annul mid-run: results keep old values, no ready; then 9/3
    prev_lo = result_lo; prev_hi = result_hi;
    a = 32'd100; b = 32'd7; hassign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_bit("annul_busy_T+10", busy, 1'b1);
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check_bit("annul_busy_T+11", busy, 1'b0);
    check_bit("annul_ready_T+11", ready, 1'b0);
    check("annul_lo_kept", result_lo, prev_lo);
    check("annul_hi_kept", result_hi, prev_hi);
    @(posedge clk); #1;
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // Reset mid-operation
    a = 32'd100; b = 32'd7; hassign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_bit("rstmid_busy", busy, 1'b0);
    check_bit("rstmid_ready", ready, 1'b0);
    check("rstmid_lo", result_lo, '0);
    check("rstmid_hi", result_hi, '0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("rstmid_idle", bad, 0);

    // Start during RUN is ignored: one ready, original operands' result
    rc0 = ready_cnt;
    sb_q.push_back('{lo: 32'd100, hi: 32'd0});
    a = 32'd1000; b = 32'd10; hassign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a = 32'd77; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #1;
    check_bit("runstart_ready_T+33", ready, 1'b1);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) bad++;
    end
    check("runstart_no_requeue", bad, 0);
    check("runstart_one_pulse", ready_cnt - rc0, 1);

    // start together with annul in IDLE is not accepted
    a = 32'd50; b = 32'd5; start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy !== 1'b0 || ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("startannul_idle", bad, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
